// File: rtl/tx_cfg_pkg.sv
// Shared widths, FSM state codes and helpers for the TX config sequencer.
package tx_cfg_pkg;

    localparam int unsigned GAIN_W  = 8;
    localparam int unsigned PINC_W  = 16;
    localparam int unsigned SCALE_W = 4;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t RAMP_DOWN = 3'd1;
    localparam state_t APPLY     = 3'd2;
    localparam state_t SETTLE    = 3'd3;
    localparam state_t RAMP_UP   = 3'd4;

    typedef struct packed {
        logic [GAIN_W-1:0]  gain;
        logic [PINC_W-1:0]  phase_inc;
        logic               pd_en;
        logic [SCALE_W-1:0] scale;
    } cfg_t;

    // Width able to hold max(step, settle) - 1, never narrower than one bit.
    function automatic int unsigned timer_width(input int unsigned step_cycles,
                                                input int unsigned settle_cycles);
        int unsigned m;
        m = (step_cycles > settle_cycles) ? step_cycles : settle_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic logic [GAIN_W-1:0] sub_floor(input logic [GAIN_W-1:0] a,
                                                    input logic [GAIN_W-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction

endpackage

// File: rtl/tx_cfg_sequencer_if.sv
// Config handshake plus datapath-facing config bus of the TX sequencer.
interface tx_cfg_sequencer_if;
    import tx_cfg_pkg::*;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [GAIN_W-1:0]  cfg_gain;
    logic [PINC_W-1:0]  cfg_phase_inc;
    logic               cfg_pd_en;
    logic [SCALE_W-1:0] cfg_scale;
    logic [15:0]        interval_max;
    logic [GAIN_W-1:0]  mixer_gain;
    logic [PINC_W-1:0]  lo_dds_phase_inc;
    logic               enable_pre_distortion;
    logic [SCALE_W-1:0] scale_select;
    logic               busy;
    logic               overload;

    modport master (
        output cfg_valid, cfg_gain, cfg_phase_inc, cfg_pd_en, cfg_scale, interval_max,
        input  cfg_ready, mixer_gain, lo_dds_phase_inc, enable_pre_distortion,
               scale_select, busy, overload
    );

    modport slave (
        input  cfg_valid, cfg_gain, cfg_phase_inc, cfg_pd_en, cfg_scale, interval_max,
        output cfg_ready, mixer_gain, lo_dds_phase_inc, enable_pre_distortion,
               scale_select, busy, overload
    );

endinterface

// File: rtl/tx_step_timer.sv
// Loadable down-counter shared by ramp-step and settle timing; holds at zero.
module tx_step_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && (cnt_q != '0))
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/tx_cfg_sequencer.sv
// Glitch-free TX config sequencer: ramp gain down, switch config, settle, ramp up.
// Optional overload backoff is built when TX_OVERLOAD_BACKOFF_EN is defined.
module tx_cfg_sequencer
    import tx_cfg_pkg::*;
#(
    parameter logic [GAIN_W-1:0] GAIN_STEP     = 8'd4,
    parameter int unsigned       STEP_CYCLES   = 16,
    parameter int unsigned       SETTLE_CYCLES = 64,
    parameter logic [15:0]       OVL_THRESH    = 16'h7000,
    parameter int unsigned       OVL_COUNT     = 8
) (
    input logic               clock,
    input logic               reset,
    tx_cfg_sequencer_if.slave bus
);

    localparam int unsigned TMR_W = timer_width(STEP_CYCLES, SETTLE_CYCLES);
    localparam logic [TMR_W-1:0] STEP_RELOAD   = TMR_W'(STEP_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_RELOAD = TMR_W'(SETTLE_CYCLES - 1);

    state_t             state_q, state_d;
    cfg_t               shadow_q, shadow_d;
    logic [GAIN_W-1:0]  gain_q, gain_d;
    logic [PINC_W-1:0]  pinc_q, pinc_d;
    logic               pd_q, pd_d;
    logic [SCALE_W-1:0] scale_q, scale_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic               tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0]   tmr_val;
    logic [GAIN_W:0]    gain_up;
    logic               accept;
    logic               backoff;

    assign accept  = bus.cfg_valid && ready_q;
    assign gain_up = {1'b0, gain_q} + {1'b0, GAIN_STEP};

    tx_step_timer #(.W(TMR_W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        gain_d   = gain_q;
        pinc_d   = pinc_q;
        pd_d     = pd_q;
        scale_d  = scale_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = STEP_RELOAD;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shadow_d.gain      = bus.cfg_gain;
                    shadow_d.phase_inc = bus.cfg_phase_inc;
                    shadow_d.pd_en     = bus.cfg_pd_en;
                    shadow_d.scale     = bus.cfg_scale;
                    state_d            = RAMP_DOWN;
                    tmr_load           = 1'b1;
                end else if (backoff) begin
                    gain_d        = sub_floor(gain_q, GAIN_STEP);
                    shadow_d.gain = sub_floor(shadow_q.gain, GAIN_STEP);
                end
            end
            RAMP_DOWN: begin
                if (gain_q == '0) begin
                    state_d = APPLY;
                end else if (tmr_zero) begin
                    gain_d   = sub_floor(gain_q, GAIN_STEP);
                    tmr_load = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            APPLY: begin
                pinc_d   = shadow_q.phase_inc;
                pd_d     = shadow_q.pd_en;
                scale_d  = shadow_q.scale;
                tmr_val  = SETTLE_RELOAD;
                tmr_load = 1'b1;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (tmr_zero) begin
                    state_d  = RAMP_UP;
                    tmr_load = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            RAMP_UP: begin
                if (gain_q == shadow_q.gain) begin
                    state_d = IDLE;
                end else if (tmr_zero) begin
                    // 9-bit sum so a step past 8'hFF clamps instead of wrapping.
                    gain_d   = (gain_up > {1'b0, shadow_q.gain}) ? shadow_q.gain
                                                                 : gain_up[GAIN_W-1:0];
                    tmr_load = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            gain_q   <= '0;
            pinc_q   <= '0;
            pd_q     <= 1'b0;
            scale_q  <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            gain_q   <= gain_d;
            pinc_q   <= pinc_d;
            pd_q     <= pd_d;
            scale_q  <= scale_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

`ifdef TX_OVERLOAD_BACKOFF_EN
    localparam int unsigned OVL_W = $clog2(OVL_COUNT + 1);

    logic [OVL_W-1:0] ovl_cnt_q, ovl_cnt_d;
    logic             ovl_flag_q, ovl_flag_d;
    logic             ovl_hit;

    assign ovl_hit = (ovl_cnt_q == OVL_W'(OVL_COUNT));
    // A saturated count waits out a busy sequence and fires on return to IDLE.
    assign backoff = (state_q == IDLE) && !accept && ovl_hit;

    always_comb begin
        ovl_cnt_d  = ovl_cnt_q;
        ovl_flag_d = ovl_flag_q;
        if (backoff || (bus.interval_max < OVL_THRESH))
            ovl_cnt_d = '0;
        else if (!ovl_hit)
            ovl_cnt_d = ovl_cnt_q + OVL_W'(1);
        if (accept)
            ovl_flag_d = 1'b0;
        else if (backoff)
            ovl_flag_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovl_cnt_q  <= '0;
            ovl_flag_q <= 1'b0;
        end else begin
            ovl_cnt_q  <= ovl_cnt_d;
            ovl_flag_q <= ovl_flag_d;
        end
    end

    assign bus.overload = ovl_flag_q;
`else
    logic ovl_unused;
    assign ovl_unused   = ^{bus.interval_max, OVL_THRESH} ^ (OVL_COUNT == 0);
    assign backoff      = 1'b0;
    assign bus.overload = 1'b0;
`endif

    assign bus.cfg_ready             = ready_q;
    assign bus.busy                  = busy_q;
    assign bus.mixer_gain            = gain_q;
    assign bus.lo_dds_phase_inc      = pinc_q;
    assign bus.enable_pre_distortion = pd_q;
    assign bus.scale_select          = scale_q;

endmodule

// File: tb/tb_tx_cfg_sequencer.sv
// Directed self-checking bench for tx_cfg_sequencer (GAIN_STEP=0x10, STEP=4, SETTLE=8).
module tb_tx_cfg_sequencer;

    logic clock  = 1'b0;
    logic reset  = 1'b0;
    logic clk_en = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned lat;

    tx_cfg_sequencer_if bus ();

    tx_cfg_sequencer #(
        .GAIN_STEP     (8'h10),
        .STEP_CYCLES   (4),
        .SETTLE_CYCLES (8),
        .OVL_THRESH    (16'h7000),
        .OVL_COUNT     (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 if (clk_en) clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Presents a config and takes the edge that should accept it.
    task automatic send(input logic [7:0] g, input logic [15:0] p,
                        input logic pd, input logic [3:0] s);
        bus.cfg_valid     = 1'b1;
        bus.cfg_gain      = g;
        bus.cfg_phase_inc = p;
        bus.cfg_pd_en     = pd;
        bus.cfg_scale     = s;
        step(1);
        bus.cfg_valid = 1'b0;
        check("accept_busy", bus.busy, 1);
    endtask

    task automatic wait_idle(input int unsigned limit, output int unsigned n);
        n = 0;
        while (bus.busy && (n < limit)) begin
            step(1);
            n++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gain"},  bus.mixer_gain, 0);
        check({tag, "_pinc"},  bus.lo_dds_phase_inc, 0);
        check({tag, "_pd"},    bus.enable_pre_distortion, 0);
        check({tag, "_scale"}, bus.scale_select, 0);
        check({tag, "_ready"}, bus.cfg_ready, 1);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_ovl"},   bus.overload, 0);
    endtask

    initial begin
        bus.cfg_valid     = 1'b0;
        bus.cfg_gain      = '0;
        bus.cfg_phase_inc = '0;
        bus.cfg_pd_en     = 1'b0;
        bus.cfg_scale     = '0;
        bus.interval_max  = '0;

        // Async reset with the clock stopped
        #3 reset = 1'b1;
        #1 check_all_zero("rst_noclk");
        #4 clk_en = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);

        // A: 0 -> 0x40, no ramp-down steps; 27 edges accept to IDLE
        send(8'h40, 16'h0111, 1'b0, 4'h2);
        check("a_ready_drop", bus.cfg_ready, 0);
        step(1);
        check("a_pinc_hold", bus.lo_dds_phase_inc, 16'h0000);
        step(1);
        check("a_pinc_apply", bus.lo_dds_phase_inc, 16'h0111);
        check("a_scale_apply", bus.scale_select, 4'h2);
        wait_idle(100, lat);
        check("a_latency", lat, 25);
        check("a_gain", bus.mixer_gain, 8'h40);

        // B: 0x40 -> 0x23 while a second config C is held on the bus
        send(8'h23, 16'h1234, 1'b1, 4'h5);
        bus.cfg_valid     = 1'b1;
        bus.cfg_gain      = 8'h00;
        bus.cfg_phase_inc = 16'hBEEF;
        bus.cfg_pd_en     = 1'b0;
        bus.cfg_scale     = 4'hA;
        step(3);
        check("b_e3_gain", bus.mixer_gain, 8'h40);
        step(1);
        check("b_e4_gain", bus.mixer_gain, 8'h30);
        step(4);
        check("b_e8_gain", bus.mixer_gain, 8'h20);
        step(4);
        check("b_e12_gain", bus.mixer_gain, 8'h10);
        step(4);
        check("b_e16_gain", bus.mixer_gain, 8'h00);
        check("b_e16_pinc", bus.lo_dds_phase_inc, 16'h0111);
        step(1);
        check("b_e17_pinc", bus.lo_dds_phase_inc, 16'h0111);
        step(1);
        check("b_e18_pinc", bus.lo_dds_phase_inc, 16'h1234);
        check("b_e18_pd", bus.enable_pre_distortion, 1);
        check("b_e18_scale", bus.scale_select, 4'h5);
        check("b_e18_gain", bus.mixer_gain, 8'h00);
        check("b_e18_ready", bus.cfg_ready, 0);
        step(11);
        check("b_e29_gain", bus.mixer_gain, 8'h00);
        step(1);
        check("b_e30_gain", bus.mixer_gain, 8'h10);
        step(4);
        check("b_e34_gain", bus.mixer_gain, 8'h20);
        step(4);
        check("b_e38_gain", bus.mixer_gain, 8'h23);
        check("b_e38_busy", bus.busy, 1);
        step(1);
        check("b_e39_busy", bus.busy, 0);
        check("b_e39_ready", bus.cfg_ready, 1);

        // C accepted on the first ready cycle; target 0, 0x23 floors to 0
        step(1);
        check("c_accept_busy", bus.busy, 1);
        check("c_accept_ready", bus.cfg_ready, 0);
        bus.cfg_valid = 1'b0;
        step(8);
        check("c_e8_gain", bus.mixer_gain, 8'h03);
        step(4);
        check("c_e12_gain", bus.mixer_gain, 8'h00);
        wait_idle(100, lat);
        check("c_latency_rest", lat, 11);
        check("c_gain", bus.mixer_gain, 8'h00);
        check("c_pinc", bus.lo_dds_phase_inc, 16'hBEEF);
        check("c_scale", bus.scale_select, 4'hA);
        check("c_pd", bus.enable_pre_distortion, 0);

        // D: 0 -> 0xFF, last ramp-up step clamps at 0xFF
        send(8'hFF, 16'h5555, 1'b1, 4'hF);
        wait_idle(200, lat);
        check("d_latency", lat, 75);
        check("d_gain", bus.mixer_gain, 8'hFF);

        // E: identical config still runs the full sequence; ramp-down floors
        send(8'hFF, 16'h5555, 1'b1, 4'hF);
        step(60);
        check("e_e60_gain", bus.mixer_gain, 8'h0F);
        step(4);
        check("e_e64_gain", bus.mixer_gain, 8'h00);
        step(1);
        check("e_e65_gain", bus.mixer_gain, 8'h00);
        wait_idle(200, lat);
        check("e_latency_rest", lat, 74);
        check("e_gain", bus.mixer_gain, 8'hFF);

        // F: reset asserted mid-SETTLE
        send(8'h10, 16'h0A0A, 1'b0, 4'h3);
        step(66);
        check("f_pinc_applied", bus.lo_dds_phase_inc, 16'h0A0A);
        step(3);
        #2 reset = 1'b1;
        #1 check_all_zero("f_rst");
        step(2);
        reset = 1'b0;
        step(1);
        send(8'h20, 16'h0321, 1'b1, 4'h1);
        wait_idle(100, lat);
        check("g_latency", lat, 19);
        check("g_gain", bus.mixer_gain, 8'h20);
        check("g_pinc", bus.lo_dds_phase_inc, 16'h0321);

`ifdef TX_OVERLOAD_BACKOFF_EN
        bus.interval_max = 16'h7800;
        step(8);
        bus.interval_max = 16'h1000;
        step(2);
        check("ovl_backoff_gain", bus.mixer_gain, 8'h10);
        check("ovl_flag_set", bus.overload, 1);
        bus.interval_max = 16'h7800;
        step(7);
        bus.interval_max = 16'h1000;
        step(4);
        check("ovl_short_gain", bus.mixer_gain, 8'h10);
        check("ovl_sticky", bus.overload, 1);
        send(8'h10, 16'h0321, 1'b1, 4'h1);
        check("ovl_clear_on_accept", bus.overload, 0);
        wait_idle(100, lat);
        check("ovl_seq_latency", lat, 19);
`else
        bus.interval_max = 16'hFFFF;
        step(12);
        check("no_ovl_gain", bus.mixer_gain, 8'h20);
        check("no_ovl_flag", bus.overload, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
